// File: rtl/oam_dma_pkg.sv
// Shared definitions for the OAM DMA engine.
//   - DMA trigger register address (FF46)
//   - OAM length (160 bytes) and START delay (4 cycles)
//   - FSM state encodings IDLE / START / XFER
//   - helper that folds echo-RAM source pages (E0..FF) down by 0x20
package oam_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFER  = 2'd2
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
   localparam int          OAM_LEN        = 160;
   localparam int          START_DELAY    = 4;

   localparam logic [7:0]  ECHO_BASE      = 8'hE0;
   localparam logic [7:0]  ECHO_OFFSET    = 8'h20;
   localparam logic [7:0]  CART_ROM_LIMIT = 8'h80;

   localparam logic [15:0] HRAM_LO        = 16'hFF80;
   localparam logic [15:0] HRAM_HI        = 16'hFFFE;

   function automatic logic [7:0] fold_echo(input logic [7:0] hi);
      return (hi >= ECHO_BASE) ? (hi - ECHO_OFFSET) : hi;
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to FF46 copies 160 bytes from page
// {src_hi,00..9F} into OAM, one byte every CYCLES_PER_BYTE clocks,
// after a 4-cycle START delay.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   cpu_addr/cpu_data_in  CPU bus; cpu_wr strobes one write per cycle
//   dma_rd_data           source byte for address_bus_dma_rd
//   address_bus_dma_rd    DMA source address (0 outside XFER)
//   dma_sel_cart_rom      DMA owns the cartridge ROM bus
//   dma_active            transfer in progress (START or XFER)
//   oam_wr_en/addr/data   OAM write port
//   dma_reg_out           FF46 readback
//   cpu_bus_block         CPU stall for non-HRAM accesses
//
// Build option: define OAM_DMA_BUS_LOCK_EN to drive cpu_bus_block;
// otherwise it is tied low.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | no transfer, outputs quiet
// START  | 4-cycle delay after a trigger, start_cnt counts down
// XFER   | copying byte n, write on the last phase of each byte
module oam_dma
   import oam_dma_pkg::*;
#(
   parameter int CYCLES_PER_BYTE = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_wr,
   input  logic [7:0]  dma_rd_data,
   output logic [15:0] address_bus_dma_rd,
   output logic        dma_sel_cart_rom,
   output logic        dma_active,
   output logic        oam_wr_en,
   output logic [7:0]  oam_wr_addr,
   output logic [7:0]  oam_wr_data,
   output logic [7:0]  dma_reg_out,
   output logic        cpu_bus_block
);

   // The phase counter is 2 bits wide, so only 4 clocks per byte is legal.
   localparam logic [1:0] PHASE_LAST     = 2'(CYCLES_PER_BYTE - 1);
   localparam logic [7:0] BYTE_LAST      = 8'(OAM_LEN - 1);
   localparam logic [1:0] START_CNT_LOAD = 2'(START_DELAY - 1);

   dma_state_t state, state_nxt;
   logic [7:0] byte_idx, byte_idx_nxt;
   logic [1:0] phase, phase_nxt;
   logic [1:0] start_cnt, start_cnt_nxt;
   logic [7:0] src_hi, src_hi_nxt;

   logic       trigger;
   logic       in_xfer;
   logic       wr_slot;
   logic [7:0] eff_hi;

   assign trigger = cpu_wr && (cpu_addr == DMA_REG_ADDR);
   assign eff_hi  = fold_echo(src_hi);
   assign in_xfer = (state == ST_XFER);
   assign wr_slot = in_xfer && (phase == PHASE_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         byte_idx  <= 8'h00;
         phase     <= 2'd0;
         start_cnt <= 2'd0;
         src_hi    <= 8'hFF;
      end else begin
         state     <= state_nxt;
         byte_idx  <= byte_idx_nxt;
         phase     <= phase_nxt;
         start_cnt <= start_cnt_nxt;
         src_hi    <= src_hi_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      byte_idx_nxt  = byte_idx;
      phase_nxt     = phase;
      start_cnt_nxt = start_cnt;
      src_hi_nxt    = src_hi;

      case (state)
         ST_IDLE: begin
         end
         ST_START: begin
            if (start_cnt == 2'd0) begin
               state_nxt    = ST_XFER;
               byte_idx_nxt = 8'h00;
               phase_nxt    = 2'd0;
            end else begin
               start_cnt_nxt = start_cnt - 2'd1;
            end
         end
         ST_XFER: begin
            phase_nxt = phase + 2'd1;
            if (phase == PHASE_LAST) begin
               if (byte_idx == BYTE_LAST) begin
                  state_nxt    = ST_IDLE;
                  byte_idx_nxt = 8'h00;
               end else begin
                  byte_idx_nxt = byte_idx + 8'h01;
               end
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            byte_idx_nxt = 8'h00;
            phase_nxt    = 2'd0;
         end
      endcase

      // A trigger overrides whatever the engine was doing. The write of the
      // current cycle (if any) is combinational and has already happened,
      // so a trigger on the final write still lets that byte land.
      if (trigger) begin
         state_nxt     = ST_START;
         src_hi_nxt    = cpu_data_in;
         byte_idx_nxt  = 8'h00;
         phase_nxt     = 2'd0;
         start_cnt_nxt = START_CNT_LOAD;
      end
   end

   assign dma_active         = (state != ST_IDLE);
   assign address_bus_dma_rd = in_xfer ? {eff_hi, byte_idx} : 16'h0000;
   assign dma_sel_cart_rom   = in_xfer && (eff_hi < CART_ROM_LIMIT);
   assign oam_wr_en          = wr_slot;
   assign oam_wr_addr        = in_xfer ? byte_idx : 8'h00;
   assign oam_wr_data        = wr_slot ? dma_rd_data : 8'h00;
   assign dma_reg_out        = src_hi;

`ifdef OAM_DMA_BUS_LOCK_EN
   // HRAM (FF80..FFFE) stays reachable so the CPU can run its wait loop.
   assign cpu_bus_block = dma_active &&
                          !((cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI));
`else
   assign cpu_bus_block = 1'b0;
`endif

endmodule
